// File: rtl/ir_nec_tx.sv
// NEC IR transmitter: synchronises an on/off level and sends one NEC frame
// (CMD_ON on a rising edge, CMD_OFF on a falling edge) on a modulated carrier.
module ir_nec_tx #(
  parameter int          CLK_HZ       = 50000000,
  parameter int          UNIT_CYC     = 28125,
  parameter int          CARRIER_HALF = 657,
  parameter int          GAP_UNITS    = 72,
  parameter logic [7:0]  ADDR         = 8'h00,
  parameter logic [7:0]  CMD_ON       = 8'h45,
  parameter logic [7:0]  CMD_OFF      = 8'h46
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ctrl_in,
  output logic busy,
  output logic ir_out,
  output logic frame_done
);

  localparam int UCW  = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int CHW  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam int NMAX = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UW   = $clog2(NMAX);
  localparam logic [UCW-1:0] UNIT_LAST = UCW'(UNIT_CYC - 1);
  localparam logic [CHW-1:0] HALF_LAST = CHW'(CARRIER_HALF - 1);

  // A unit must hold at least one full carrier period.
  if (UNIT_CYC < 2 * CARRIER_HALF || CLK_HZ < 2 * CARRIER_HALF) begin : g_bad_cfg
    $error("ir_nec_tx: UNIT_CYC/CLK_HZ too small for CARRIER_HALF");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_STOP_MARK, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic             edge_q, edge_d, kind_q, kind_d;
  logic             pend_vld_q, pend_vld_d, pend_kind_q, pend_kind_d;
  logic [UCW-1:0]   unit_cnt_q, unit_cnt_d;
  logic [UW-1:0]    units_q, units_d, n_last;
  logic [4:0]       bit_idx_q, bit_idx_d;
  logic [CHW-1:0]   phase_q, phase_d;
  logic             ir_q, ir_d;
  logic [31:0]      payload_q, payload_d;
  logic             unit_tick, state_end, gap_end, start, start_kind, load;
  logic [7:0]       cmd;

  function automatic logic is_mark(input state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

  // Edge detection, frame sequencing, pending slot and carrier generation.
  always_comb begin
    sync1_d     = ctrl_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    edge_d      = sync2_q ^ prev_q;
    kind_d      = sync2_q;
    state_d     = state_q;
    unit_cnt_d  = unit_cnt_q;
    units_d     = units_q;
    bit_idx_d   = bit_idx_q;
    phase_d     = phase_q;
    ir_d        = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_kind_d = pend_kind_q;
    load        = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      S_LEAD_MARK:  n_last = UW'(15);
      S_LEAD_SPACE: n_last = UW'(7);
      S_BIT_SPACE:  n_last = payload_q[bit_idx_q] ? UW'(2) : UW'(0);
      S_GAP:        n_last = UW'(GAP_UNITS - 1);
      default:      n_last = '0;
    endcase

    unit_tick  = (unit_cnt_q == UNIT_LAST);
    state_end  = unit_tick && (units_q == n_last);
    gap_end    = (state_q == S_GAP) && state_end;
    start      = ((state_q == S_IDLE) || gap_end) && (edge_q || pend_vld_q);
    // A fresh edge is newer than whatever sits in the pending slot.
    start_kind = edge_q ? kind_q : pend_kind_q;
    cmd        = start_kind ? CMD_ON : CMD_OFF;

    if (unit_tick) begin
      unit_cnt_d = '0;
      units_d    = units_q + 1'b1;
    end else begin
      unit_cnt_d = unit_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE:       if (start) state_d = S_LEAD_MARK;
      S_LEAD_MARK:  if (state_end) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (state_end) begin
                      state_d   = S_BIT_MARK;
                      bit_idx_d = '0;
                    end
      S_BIT_MARK:   if (state_end) state_d = S_BIT_SPACE;
      S_BIT_SPACE:  if (state_end) begin
                      if (bit_idx_q == 5'd31) begin
                        state_d = S_STOP_MARK;
                      end else begin
                        state_d   = S_BIT_MARK;
                        bit_idx_d = bit_idx_q + 5'd1;
                      end
                    end
      S_STOP_MARK:  if (state_end) state_d = S_GAP;
      S_GAP:        if (state_end) begin
                      frame_done = 1'b1;
                      state_d    = start ? S_LEAD_MARK : S_IDLE;
                    end
      default:      state_d = S_IDLE;
    endcase

    // Edges during a frame park in the pending slot; the latest kind wins.
    if (start) begin
      load       = 1'b1;
      pend_vld_d = 1'b0;
    end else if (edge_q) begin
      pend_vld_d  = 1'b1;
      pend_kind_d = kind_q;
    end

    if ((state_d != state_q) || (state_d == S_IDLE)) begin
      unit_cnt_d = '0;
      units_d    = '0;
    end

    // Carrier starts high on mark entry and is forced low once the mark ends.
    if (is_mark(state_d)) begin
      if (state_d != state_q) begin
        phase_d = '0;
        ir_d    = 1'b1;
      end else if (phase_q == HALF_LAST) begin
        phase_d = '0;
        ir_d    = ~ir_q;
      end else begin
        phase_d = phase_q + 1'b1;
        ir_d    = ir_q;
      end
    end

    payload_d = load ? {~cmd, cmd, ~ADDR, ADDR} : payload_q;
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      prev_q      <= 1'b0;
      edge_q      <= 1'b0;
      kind_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_kind_q <= 1'b0;
      unit_cnt_q  <= '0;
      units_q     <= '0;
      bit_idx_q   <= '0;
      phase_q     <= '0;
      ir_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      edge_q      <= edge_d;
      kind_q      <= kind_d;
      pend_vld_q  <= pend_vld_d;
      pend_kind_q <= pend_kind_d;
      unit_cnt_q  <= unit_cnt_d;
      units_q     <= units_d;
      bit_idx_q   <= bit_idx_d;
      phase_q     <= phase_d;
      ir_q        <= ir_d;
    end
  end

  // Payload is data only; it is always loaded before it is read.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  assign busy   = (state_q != S_IDLE);
  assign ir_out = ir_q;

endmodule
